// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the symbol-counting game controller.
//   - state_t          : round-sequencer states
//   - LEVEL_W/SCORE_W  : widths of curLevel and score
//   - CNT_W            : width of the seconds counter
//   - DEF_*            : default timing constants (seconds) and level limit
//   - calc_show_secs() : display-window length for a given level
//   - sat_inc_score()  : saturating score increment
// -----------------------------------------------------------------------------
package game_pkg;

  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned CNT_W   = 5;

  localparam int unsigned DEF_MAX_LEVEL   = 9;
  localparam int unsigned DEF_SHOW_BASE   = 8;
  localparam int unsigned DEF_SHOW_MIN    = 2;
  localparam int unsigned DEF_ANS_SECS    = 10;
  localparam int unsigned DEF_RESULT_SECS = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_TMR = 3'd1,
    SHOW     = 3'd2,
    ANSWER   = 3'd3,
    RESULT   = 3'd4,
    WON      = 3'd5,
    LOST     = 3'd6
  } state_t;

  // max(min_secs, base - (level-1)) in CNT_W bits; the subtraction clamps at
  // zero instead of wrapping so high levels fall back to the floor.
  function automatic logic [CNT_W-1:0] calc_show_secs(input logic [LEVEL_W-1:0] level,
                                                      input int unsigned        base,
                                                      input int unsigned        min_secs);
    logic [CNT_W-1:0] lvl_m1;
    logic [CNT_W-1:0] base_w;
    logic [CNT_W-1:0] min_w;
    logic [CNT_W-1:0] diff;
    lvl_m1 = (level == '0) ? '0 : (CNT_W'(level) - CNT_W'(1));
    base_w = CNT_W'(base);
    min_w  = CNT_W'(min_secs);
    diff   = (base_w > lvl_m1) ? (base_w - lvl_m1) : '0;
    return (diff > min_w) ? diff : min_w;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] value);
    return (value == '1) ? value : (value + SCORE_W'(1));
  endfunction

endpackage

// File: rtl/sec_down_counter.sv
// -----------------------------------------------------------------------------
// sec_down_counter
// Loadable seconds counter decremented by the 1 Hz tick. One instance is
// shared by the SHOW, ANSWER and RESULT phases of the sequencer.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset (count clears to 0)
//   tick     - one-cycle 1 Hz pulse
//   load     - load load_val this cycle (wins over tick)
//   load_val - value to load
//   last     - tick arriving while count==1, i.e. the window's final second
// -----------------------------------------------------------------------------
module sec_down_counter
  import game_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             last
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign last = tick & (cnt_q == WIDTH'(1));

endmodule

// File: rtl/level_sequencer.sv
// -----------------------------------------------------------------------------
// level_sequencer
// Game-flow controller: per level it starts the countdown timer, opens the
// symbol display window, collects and checks the answer, then advances the
// level or ends the game.
// Ports:
//   Clk100M       - system clock, rising edge
//   Rst_n         - asynchronous active-low reset
//   tick1Hz       - one-cycle pulse per second
//   startBtn      - debounced start button (level; rising edge used)
//   timerDone     - countdown-finished pulse from the timer
//   answerValid   - strobe qualifying answer
//   answer        - player's count
//   expectedCount - true symbol count from the symbol generator
//   timerStart    - one-cycle timer start pulse
//   curLevel      - current level, 1..MAX_LEVEL
//   symReq        - one-cycle request for a new symbol set
//   showSymbols   - symbols displayed
//   answerOpen    - answer accepted
//   roundPass     - result phase, answer correct
//   roundFail     - result phase, answer wrong or timed out
//   gameWon       - game won
//   gameLost      - game lost
//   score         - correctly answered rounds, saturating
// -----------------------------------------------------------------------------
module level_sequencer
  import game_pkg::*;
#(
  parameter int unsigned MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int unsigned SHOW_BASE   = DEF_SHOW_BASE,
  parameter int unsigned SHOW_MIN    = DEF_SHOW_MIN,
  parameter int unsigned ANS_SECS    = DEF_ANS_SECS,
  parameter int unsigned RESULT_SECS = DEF_RESULT_SECS
) (
  input  logic               Clk100M,
  input  logic               Rst_n,
  input  logic               tick1Hz,
  input  logic               startBtn,
  input  logic               timerDone,
  input  logic               answerValid,
  input  logic [3:0]         answer,
  input  logic [3:0]         expectedCount,
  output logic               timerStart,
  output logic [LEVEL_W-1:0] curLevel,
  output logic               symReq,
  output logic               showSymbols,
  output logic               answerOpen,
  output logic               roundPass,
  output logic               roundFail,
  output logic               gameWon,
  output logic               gameLost,
  output logic [SCORE_W-1:0] score
);

  localparam logic [LEVEL_W-1:0] LevelOne = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] LevelMax = LEVEL_W'(MAX_LEVEL);

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               correct_q, correct_d;
  logic               start_q;
  logic               rise;
  // timerStart and symReq always fire together, so they share one register.
  logic               pulse_q, pulse_d;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_last;

  assign rise = startBtn & ~start_q;

  sec_down_counter #(
    .WIDTH (CNT_W)
  ) u_sec_cnt (
    .clk      (Clk100M),
    .rst_n    (Rst_n),
    .tick     (tick1Hz),
    .load     (cnt_load),
    .load_val (cnt_val),
    .last     (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    score_d   = score_q;
    correct_d = correct_q;
    pulse_d   = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          pulse_d = 1'b1;
          state_d = WAIT_TMR;
        end
      end

      WAIT_TMR: begin
        if (timerDone) begin
          cnt_load = 1'b1;
          cnt_val  = calc_show_secs(level_q, SHOW_BASE, SHOW_MIN);
          state_d  = SHOW;
        end
      end

      SHOW: begin
        if (cnt_last) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(ANS_SECS);
          state_d  = ANSWER;
        end
      end

      ANSWER: begin
        // An answer landing on the final tick still counts.
        if (answerValid) begin
          correct_d = (answer == expectedCount);
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(RESULT_SECS);
          state_d   = RESULT;
          if (answer == expectedCount) begin
            score_d = sat_inc_score(score_q);
          end
        end else if (cnt_last) begin
          correct_d = 1'b0;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(RESULT_SECS);
          state_d   = RESULT;
        end
      end

      RESULT: begin
        if (cnt_last) begin
          if (!correct_q) begin
            state_d = LOST;
          end else if (level_q == LevelMax) begin
            state_d = WON;
          end else begin
            level_d = level_q + LEVEL_W'(1);
            pulse_d = 1'b1;
            state_d = WAIT_TMR;
          end
        end
      end

      WON, LOST: begin
        if (rise) begin
          level_d = LevelOne;
          score_d = '0;
          pulse_d = 1'b1;
          state_d = WAIT_TMR;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      level_q   <= LevelOne;
      score_q   <= '0;
      correct_q <= 1'b0;
      start_q   <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      score_q   <= score_d;
      correct_q <= correct_d;
      start_q   <= startBtn;
      pulse_q   <= pulse_d;
    end
  end

  // Flags decode straight from the state register so reset clears them at once.
  assign timerStart  = pulse_q;
  assign symReq      = pulse_q;
  assign curLevel    = level_q;
  assign score       = score_q;
  assign showSymbols = (state_q == SHOW);
  assign answerOpen  = (state_q == ANSWER);
  assign roundPass   = (state_q == RESULT) & correct_q;
  assign roundFail   = (state_q == RESULT) & ~correct_q;
  assign gameWon     = (state_q == WON);
  assign gameLost    = (state_q == LOST);

endmodule

// File: tb/tb_level_sequencer.sv
module tb_level_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       timer_done = 1'b0;
  logic       answer_valid = 1'b0;
  logic [3:0] answer = 4'd0;
  logic [3:0] expected_count = 4'd5;

  logic       timer_start, sym_req, show_symbols, answer_open;
  logic       round_pass, round_fail, game_won, game_lost;
  logic [3:0] cur_level;
  logic [7:0] score;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  level_sequencer dut (
    .Clk100M       (clk),
    .Rst_n         (rst_n),
    .tick1Hz       (tick),
    .startBtn      (start_btn),
    .timerDone     (timer_done),
    .answerValid   (answer_valid),
    .answer        (answer),
    .expectedCount (expected_count),
    .timerStart    (timer_start),
    .curLevel      (cur_level),
    .symReq        (sym_req),
    .showSymbols   (show_symbols),
    .answerOpen    (answer_open),
    .roundPass     (round_pass),
    .roundFail     (round_fail),
    .gameWon       (game_won),
    .gameLost      (game_lost),
    .score         (score)
  );

  // Stimulus helpers; every sample point is 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_pulse();
    step(2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic pulse_done();
    timer_done = 1'b1;
    step(1);
    timer_done = 1'b0;
  endtask

  task automatic give_answer(input logic [3:0] value);
    answer = value;
    answer_valid = 1'b1;
    step(1);
    answer_valid = 1'b0;
  endtask

  function automatic logic [7:0] flags();
    return {timer_start, sym_req, show_symbols, answer_open,
            round_pass, round_fail, game_won, game_lost};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    checks++; if (cur_level !== 4'd1) begin errors++;
      $display("FAIL reset_level: got %0d expected 1", cur_level); end
    checks++; if (score !== 8'd0) begin errors++;
      $display("FAIL reset_score: got %0d expected 0", score); end
    checks++; if (flags() !== 8'h00) begin errors++;
      $display("FAIL reset_flags: got %b expected 00000000", flags()); end
    rst_n = 1'b1;
    step(2);
    // timerDone and answerValid mean nothing in IDLE
    pulse_done();
    give_answer(4'd5);
    tick_pulse();
    step(1);
    checks++; if (flags() !== 8'h00) begin errors++;
      $display("FAIL idle_ignore: got %b expected 00000000", flags()); end
  endtask

  task automatic test_start_show();
    int n;
    start_btn = 1'b1;
    step(1);
    checks++; if ({timer_start, sym_req} !== 2'b11) begin errors++;
      $display("FAIL start_pulse: got %b expected 11", {timer_start, sym_req}); end
    step(1);  // button still held: no second pulse
    checks++; if ({timer_start, sym_req} !== 2'b00) begin errors++;
      $display("FAIL start_one_cycle: got %b expected 00", {timer_start, sym_req}); end
    start_btn = 1'b0;
    repeat (6) tick_pulse();
    checks++; if (show_symbols !== 1'b0) begin errors++;
      $display("FAIL wait_timer: showSymbols=%b expected 0", show_symbols); end
    pulse_done();
    checks++; if (show_symbols !== 1'b1) begin errors++;
      $display("FAIL done_to_show: showSymbols=%b expected 1", show_symbols); end
    give_answer(4'd3);  // answer during SHOW is ignored
    checks++; if ({show_symbols, round_pass, round_fail} !== 3'b100) begin errors++;
      $display("FAIL show_ignore_answer: got %b expected 100",
               {show_symbols, round_pass, round_fail}); end
    n = 0;
    while (show_symbols && n < 20) begin tick_pulse(); n++; end
    checks++; if (n !== 8) begin errors++;
      $display("FAIL show_len_l1: got %0d ticks expected 8", n); end
    checks++; if (answer_open !== 1'b1) begin errors++;
      $display("FAIL answer_open: got %b expected 1", answer_open); end
  endtask

  task automatic test_correct_answer();
    int n;
    give_answer(4'd5);
    checks++; if ({round_pass, round_fail} !== 2'b10) begin errors++;
      $display("FAIL pass_flag: got %b expected 10", {round_pass, round_fail}); end
    checks++; if (score !== 8'd1) begin errors++;
      $display("FAIL score_inc: got %0d expected 1", score); end
    n = 0;
    while (round_pass && n < 20) begin tick_pulse(); n++; end
    checks++; if (n !== 2) begin errors++;
      $display("FAIL pass_len: got %0d ticks expected 2", n); end
    checks++; if (cur_level !== 4'd2) begin errors++;
      $display("FAIL level_adv: got %0d expected 2", cur_level); end
    checks++; if ({timer_start, sym_req} !== 2'b11) begin errors++;
      $display("FAIL next_pulse: got %b expected 11", {timer_start, sym_req}); end
    step(1);
    checks++; if ({timer_start, sym_req} !== 2'b00) begin errors++;
      $display("FAIL next_pulse_end: got %b expected 00", {timer_start, sym_req}); end
    pulse_done();
    n = 0;
    while (show_symbols && n < 20) begin tick_pulse(); n++; end
    checks++; if (n !== 7) begin errors++;
      $display("FAIL show_len_l2: got %0d ticks expected 7", n); end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    while (answer_open && n < 20) begin tick_pulse(); n++; end
    checks++; if (n !== 10) begin errors++;
      $display("FAIL answer_timeout: got %0d ticks expected 10", n); end
    checks++; if ({round_pass, round_fail} !== 2'b01) begin errors++;
      $display("FAIL fail_flag: got %b expected 01", {round_pass, round_fail}); end
    n = 0;
    while (round_fail && n < 20) begin tick_pulse(); n++; end
    checks++; if (n !== 2) begin errors++;
      $display("FAIL fail_len: got %0d ticks expected 2", n); end
    checks++; if ({game_lost, game_won, timer_start} !== 3'b100) begin errors++;
      $display("FAIL lost_flag: got %b expected 100", {game_lost, game_won, timer_start}); end
    checks++; if (cur_level !== 4'd2 || score !== 8'd1) begin errors++;
      $display("FAIL lost_hold: level=%0d score=%0d expected 2/1", cur_level, score); end
  endtask

  task automatic test_win();
    int n;
    int exp_show;
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    checks++; if (cur_level !== 4'd1 || score !== 8'd0 || timer_start !== 1'b1) begin errors++;
      $display("FAIL restart_lost: level=%0d score=%0d ts=%b expected 1/0/1",
               cur_level, score, timer_start); end
    for (int lvl = 1; lvl <= 9; lvl++) begin
      pulse_done();
      n = 0;
      while (show_symbols && n < 20) begin tick_pulse(); n++; end
      exp_show = (9 - lvl > 2) ? 9 - lvl : 2;
      checks++; if (n !== exp_show) begin errors++;
        $display("FAIL show_len_lvl%0d: got %0d ticks expected %0d", lvl, n, exp_show); end
      give_answer(4'd5);
      n = 0;
      while (round_pass && n < 20) begin tick_pulse(); n++; end
    end
    checks++; if ({game_won, game_lost, timer_start} !== 3'b100) begin errors++;
      $display("FAIL won_flag: got %b expected 100", {game_won, game_lost, timer_start}); end
    checks++; if (score !== 8'd9 || cur_level !== 4'd9) begin errors++;
      $display("FAIL won_state: score=%0d level=%0d expected 9/9", score, cur_level); end
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    checks++; if (cur_level !== 4'd1 || score !== 8'd0 || timer_start !== 1'b1
                  || game_won !== 1'b0) begin errors++;
      $display("FAIL restart_won: level=%0d score=%0d ts=%b won=%b expected 1/0/1/0",
               cur_level, score, timer_start, game_won); end
  endtask

  task automatic test_same_cycle();
    int n;
    pulse_done();
    n = 0;
    while (show_symbols && n < 20) begin tick_pulse(); n++; end
    repeat (9) tick_pulse();
    checks++; if (answer_open !== 1'b1) begin errors++;
      $display("FAIL before_last_tick: answerOpen=%b expected 1", answer_open); end
    step(2);
    tick = 1'b1;
    answer = 4'd5;
    answer_valid = 1'b1;
    step(1);
    tick = 1'b0;
    answer_valid = 1'b0;
    checks++; if ({round_pass, round_fail} !== 2'b10 || score !== 8'd1) begin errors++;
      $display("FAIL same_cycle: flags=%b score=%0d expected 10/1",
               {round_pass, round_fail}, score); end
    n = 0;
    while (round_pass && n < 20) begin tick_pulse(); n++; end
    checks++; if (cur_level !== 4'd2) begin errors++;
      $display("FAIL same_cycle_adv: got %0d expected 2", cur_level); end
  endtask

  task automatic test_reset_midround();
    int n;
    pulse_done();
    n = 0;
    while (show_symbols && n < 20) begin tick_pulse(); n++; end
    give_answer(4'd5);
    n = 0;
    while (round_pass && n < 20) begin tick_pulse(); n++; end
    pulse_done();
    n = 0;
    while (show_symbols && n < 20) begin tick_pulse(); n++; end
    checks++; if (answer_open !== 1'b1 || cur_level !== 4'd3 || score !== 8'd2) begin errors++;
      $display("FAIL pre_reset: open=%b level=%0d score=%0d expected 1/3/2",
               answer_open, cur_level, score); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (cur_level !== 4'd1 || score !== 8'd0 || flags() !== 8'h00) begin errors++;
      $display("FAIL async_reset: level=%0d score=%0d flags=%b expected 1/0/00000000",
               cur_level, score, flags()); end
    step(2);
    rst_n = 1'b1;
    step(2);
    pulse_done();
    tick_pulse();
    give_answer(4'd5);
    step(1);
    checks++; if (flags() !== 8'h00 || cur_level !== 4'd1) begin errors++;
      $display("FAIL post_reset_idle: flags=%b level=%0d expected 00000000/1",
               flags(), cur_level); end
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    checks++; if ({timer_start, sym_req} !== 2'b11) begin errors++;
      $display("FAIL post_reset_start: got %b expected 11", {timer_start, sym_req}); end
  endtask

  initial begin
    test_reset();
    test_start_show();
    test_correct_answer();
    test_timeout();
    test_win();
    test_same_cycle();
    test_reset_midround();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Game-flow controller for the symbol-counting game. Sequences one round per level:
  1. Triggers the countdown timer.
  2. Opens the symbol display window for a level-dependent number of seconds.
  3. Collects and checks the player's answer.
  4. Advances the level or ends the game.
- Sits between the button/switch front end and the countdown-timer, symbol-generator and scoreboard blocks. It is the only driver of the timer's start input and of curLevel.

Parameters:
- MAX_LEVEL, 9, highest level number; clearing it produces the win condition.
- SHOW_BASE, 8, display-window seconds at level 1.
- SHOW_MIN, 2, floor on the display window, in seconds.
- ANS_SECS, 10, answer timeout in seconds.
- RESULT_SECS, 2, hold time of the result indication, in seconds.

Ports:
- Clk100M  in  1  system clock; all logic is on its rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- tick1Hz  in  1  one-cycle pulse per second, synchronous to Clk100M.
- startBtn  in  1  debounced start button, level. Only its rising edge is used.
- timerDone  in  1  one-cycle pulse from the countdown timer when its countdown ends.
- answerValid  in  1  one-cycle strobe qualifying answer.
- answer  in  4  player's count, 0-15.
- expectedCount  in  4  symbol generator's true count. Stable from symReq+1 until the next symReq.
- timerStart  out  1  one-cycle pulse that starts the countdown timer.
- curLevel  out  4  current level, 1..MAX_LEVEL.
- symReq  out  1  one-cycle pulse requesting a new symbol set.
- showSymbols  out  1  high while symbols are displayed.
- answerOpen  out  1  high while an answer is accepted.
- roundPass  out  1  high during RESULT when the answer was correct.
- roundFail  out  1  high during RESULT when the answer was wrong or timed out.
- gameWon  out  1  high in state WON.
- gameLost  out  1  high in state LOST.
- score  out  8  count of correctly answered rounds; saturates at 255.

Behaviour:
- Reset: state=IDLE, curLevel=1, score=0, secCnt=0, and all pulse/flag outputs 0.
- Reset is honoured in any state, mid-round included; outputs return to the reset values asynchronously.
- startBtn is registered once; rise = startBtn & ~startBtn_q.
- States and transitions:
  - IDLE: on rise, assert timerStart and symReq for exactly one cycle, then go to WAIT_TMR.
  - WAIT_TMR: wait for timerDone. Then load secCnt=showSecs and go to SHOW.
    - showSecs = max(SHOW_MIN, SHOW_BASE - (curLevel-1)), computed in 5-bit unsigned with no underflow.
  - SHOW: showSymbols=1. On each tick1Hz, secCnt decrements. When a tick arrives with secCnt==1, load secCnt=ANS_SECS and go to ANSWER on the next cycle.
  - ANSWER: answerOpen=1.
    - If answerValid: correct = (answer==expectedCount). Load secCnt=RESULT_SECS and go to RESULT.
    - Else, when a tick arrives with secCnt==1: timeout, correct=0, go to RESULT.
    - If answerValid and the final tick land in the same cycle, the answer wins.
  - RESULT: roundPass=correct, roundFail=~correct. When a tick arrives with secCnt==1, leave as follows:
    - correct and curLevel==MAX_LEVEL: go to WON.
    - correct: curLevel+1, assert timerStart and symReq pulses, go to WAIT_TMR.
    - not correct: go to LOST.
  - On correct, score increments on the RESULT entry cycle.
  - WON/LOST: hold the flag. On rise, reset curLevel=1 and score=0, pulse timerStart and symReq, go to WAIT_TMR.
- Inputs arriving outside their state are ignored:
  - answerValid outside ANSWER.
  - timerDone outside WAIT_TMR.
  - rise outside IDLE/WON/LOST.
- A timerStart pulse is never issued within 2 cycles of a previous one.
- Second granularity: the first tick after a state is entered counts as a full second. Windows can therefore be up to one second short; this is accepted.
- Latency:
  - rise to timerStart: 1 cycle.
  - timerDone to showSymbols: 1 cycle.
  - answerValid to roundPass/roundFail: 1 cycle.

Decomposition:
- Package game_pkg holds:
  - the state enum (IDLE, WAIT_TMR, SHOW, ANSWER, RESULT, WON, LOST);
  - the widths LEVEL_W=4 and SCORE_W=8;
  - the default timing constants.
- One sub-module, sec_down_counter: a loadable counter decremented by tick1Hz, with a last-tick output. It is shared by SHOW, ANSWER and RESULT.

Test Plan:
- Reset while in ANSWER at level 3 with score=2 -> curLevel=1, score=0, all outputs 0 immediately; IDLE until the next rise.
- startBtn rise; timerDone after 6 ticks -> timerStart and symReq one-cycle pulses; showSymbols high for 8 ticks at level 1.
- ANSWER with expectedCount=5, answer=5 valid -> roundPass for 2 ticks, score=1, curLevel=2, timerStart pulse. The next SHOW window is 7 ticks.
- No answerValid for 10 ticks -> roundFail for 2 ticks, then gameLost=1, curLevel unchanged.
- Level 9 at SHOW_MIN=2; correct answer -> gameWon=1, score=9. Then startBtn rise -> curLevel=1, score=0, timerStart pulse.
- answerValid on the same cycle as the final ANSWER tick, answer correct -> roundPass. answerValid during SHOW or IDLE -> no effect.
